// File: rtl/tictac_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tictac_pkg
//  Purpose  : Shared constants and types for the tic-tac-toe judge datapath:
//             board/line counts, the winning-line table, index typedefs and
//             the judge FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package tictac_pkg;

  localparam int NUM_CELLS = 9;
  localparam int NUM_LINES = 8;

  typedef logic [3:0] cell_idx_t;
  typedef logic [2:0] line_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } judge_state_t;

  // Cells of each winning line, row-major cell numbering (row*3+col).
  // Order matters: the judge reports the first winning line in this order.
  localparam cell_idx_t LINE_TABLE [NUM_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},   // row 0
    '{4'd3, 4'd4, 4'd5},   // row 1
    '{4'd6, 4'd7, 4'd8},   // row 2
    '{4'd0, 4'd3, 4'd6},   // column 0
    '{4'd1, 4'd4, 4'd7},   // column 1
    '{4'd2, 4'd5, 4'd8},   // column 2
    '{4'd0, 4'd4, 4'd8},   // main diagonal
    '{4'd2, 4'd4, 4'd6}    // anti-diagonal
  };

endpackage
`default_nettype wire

// File: rtl/tictac_line_check.sv
`default_nettype none
// ============================================================================
//  Module   : tictac_line_check
//  Purpose  : Combinational test of one three-cell line: the line is a hit
//             when all three cells are occupied by the same symbol.
//  Ports    : valid_a/b/c   in  cell occupied flags
//             symbol_a/b/c  in  cell symbols (meaningful when valid)
//             hit           out line complete with a single symbol
//             hit_symbol    out symbol of the line, 0 when hit=0
//  Revision : 1.0  initial release
// ============================================================================
module tictac_line_check (
  input  logic valid_a,
  input  logic symbol_a,
  input  logic valid_b,
  input  logic symbol_b,
  input  logic valid_c,
  input  logic symbol_c,
  output logic hit,
  output logic hit_symbol
);

  assign hit        = valid_a & valid_b & valid_c &
                      (symbol_a == symbol_b) & (symbol_b == symbol_c);
  assign hit_symbol = hit & symbol_a;

endmodule
`default_nettype wire

// File: rtl/tictac_judge.sv
`default_nettype none
// ============================================================================
//  Module   : tictac_judge
//  Purpose  : Snapshots the nine cell valid/symbol flags on start, then scans
//             the eight winning lines one per clock. Publishes win / winning
//             line and symbol, or draw, with a one-cycle done pulse.
//  Ports    : clk          in  clock, rising edge
//             reset_n      in  asynchronous active-low reset
//             cell_valid   in  [8:0] per-cell occupied flags
//             cell_symbol  in  [8:0] per-cell symbols
//             start        in  evaluation request, honoured only in IDLE
//             busy         out scan in progress
//             done         out one-cycle verdict pulse
//             win          out a line is complete with one symbol
//             win_symbol   out symbol of the winning line
//             win_line     out [2:0] index of the winning line
//             draw         out board full with no winning line
//  Revision : 1.0  initial release
// ============================================================================
module tictac_judge
  import tictac_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CELLS-1:0] cell_valid,
  input  logic [NUM_CELLS-1:0] cell_symbol,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 win,
  output logic                 win_symbol,
  output logic [2:0]           win_line,
  output logic                 draw
);

  judge_state_t         state;
  judge_state_t         state_next;
  line_idx_t            line_idx;
  logic [NUM_CELLS-1:0] snap_valid;
  logic [NUM_CELLS-1:0] snap_symbol;

  logic      capture;
  logic      latch_win;
  logic      latch_draw;
  logic      advance;

  cell_idx_t cell_a;
  cell_idx_t cell_b;
  cell_idx_t cell_c;
  logic      hit;
  logic      hit_symbol;

  // Only the snapshot feeds the checker, so cell inputs moving mid-scan
  // cannot influence the verdict.
  assign cell_a = LINE_TABLE[line_idx][0];
  assign cell_b = LINE_TABLE[line_idx][1];
  assign cell_c = LINE_TABLE[line_idx][2];

  tictac_line_check u_line_check (
    .valid_a    (snap_valid[cell_a]),
    .symbol_a   (snap_symbol[cell_a]),
    .valid_b    (snap_valid[cell_b]),
    .symbol_b   (snap_symbol[cell_b]),
    .valid_c    (snap_valid[cell_c]),
    .symbol_c   (snap_symbol[cell_c]),
    .hit        (hit),
    .hit_symbol (hit_symbol)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    latch_win  = 1'b0;
    latch_draw = 1'b0;
    advance    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (hit) begin
          // Early exit: the first winning line in table order is final.
          latch_win  = 1'b1;
          state_next = REPORT;
        end else if (line_idx == 3'd7) begin
          latch_draw = 1'b1;
          state_next = REPORT;
        end else begin
          advance = 1'b1;
        end
      end
      REPORT: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_idx    <= '0;
      snap_valid  <= '0;
      snap_symbol <= '0;
      win         <= 1'b0;
      win_symbol  <= 1'b0;
      win_line    <= 3'd0;
      draw        <= 1'b0;
    end else begin
      if (capture) begin
        snap_valid  <= cell_valid;
        snap_symbol <= cell_symbol;
        line_idx    <= '0;
        win         <= 1'b0;
        win_symbol  <= 1'b0;
        win_line    <= 3'd0;
        draw        <= 1'b0;
      end
      if (latch_win) begin
        win        <= 1'b1;
        win_symbol <= hit_symbol;
        win_line   <= line_idx;
      end
      // Reached only when no line hit, so a full board here is a draw.
      if (latch_draw) begin
        draw <= &snap_valid;
      end
      if (advance) begin
        line_idx <= line_idx + 3'd1;
      end
    end
  end

endmodule
`default_nettype wire
